// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous data memory between the CPU MEM stage and a debug/loader port.
// Every access takes an issue cycle and a response cycle. The CPU wins ties until MAX_CPU_BURST grants have starved debug.
module dmem_arbiter #(
    parameter int MEM_AW        = 5,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [63:0]       cpu_addr,
    input  logic [63:0]       cpu_wdata,
    output logic [63:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_misalign,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [MEM_AW-1:0] dbg_addr,
    input  logic [63:0]       dbg_wdata,
    output logic [63:0]       dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, CPU_RESP, DBG_RESP} state_t;

    localparam int            CW        = $clog2(MAX_CPU_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_CPU_BURST);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_burst_cnt;
    logic          r_resp_rd;
    logic          r_resp_mis;
    logic [63:0]   r_cpu_rdata;
    logic [63:0]   r_dbg_rdata;
    logic          w_cpu_win;
    logic          w_dbg_win;
    logic          w_mis;
    logic          w_unused_addr;

    // Address bits above the memory depth are deliberately ignored (wrap-around).
    assign w_unused_addr = ^cpu_addr[63:MEM_AW+3];

    always_comb begin
        w_next_state = r_state;
        w_cpu_win    = 1'b0;
        w_dbg_win    = 1'b0;
        if (!reset) begin
            case (r_state)
                IDLE: begin
                    if (cpu_req && !(dbg_req && r_burst_cnt == BURST_MAX)) begin
                        w_cpu_win = 1'b1;
                    end else if (dbg_req) begin
                        w_dbg_win = 1'b1;
                    end
                    if (w_cpu_win) begin
                        w_next_state = CPU_RESP;
                    end else if (w_dbg_win) begin
                        w_next_state = DBG_RESP;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // A misaligned CPU access is granted a response slot but never touches memory.
    assign w_mis        = w_cpu_win && (cpu_addr[2:0] != 3'b000);
    assign cpu_misalign = w_mis;
    assign mem_en       = w_dbg_win || (w_cpu_win && !w_mis);
    assign mem_we       = w_dbg_win ? dbg_we : (w_cpu_win && !w_mis && cpu_we);
    assign mem_addr     = w_dbg_win ? dbg_addr : cpu_addr[MEM_AW+2:3];
    assign mem_wdata    = w_dbg_win ? dbg_wdata : cpu_wdata;

    assign cpu_stall = !reset && cpu_req && (r_state != CPU_RESP);
    assign dbg_ack   = !reset && (r_state == DBG_RESP);

    // Read data is forwarded straight from memory during the response cycle, then held.
    assign cpu_rdata = (!reset && r_state == CPU_RESP && r_resp_rd)
                       ? (r_resp_mis ? 64'd0 : mem_rdata) : r_cpu_rdata;
    assign dbg_rdata = (!reset && r_state == DBG_RESP && r_resp_rd) ? mem_rdata : r_dbg_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_resp_rd   <= 1'b0;
            r_resp_mis  <= 1'b0;
            r_cpu_rdata <= '0;
            r_dbg_rdata <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cpu_rdata <= cpu_rdata;
            r_dbg_rdata <= dbg_rdata;
            if (w_cpu_win) begin
                r_resp_rd  <= !cpu_we || w_mis;
                r_resp_mis <= w_mis;
            end else if (w_dbg_win) begin
                r_resp_rd  <= !dbg_we;
                r_resp_mis <= 1'b0;
            end
            if (!dbg_req || w_dbg_win) begin
                r_burst_cnt <= '0;
            end else if (w_cpu_win && r_burst_cnt != BURST_MAX) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized single accesses against a golden memory image.
module tb_dmem_arbiter;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we;
    logic [63:0]   cpu_addr, cpu_wdata, cpu_rdata;
    logic          cpu_stall, cpu_misalign;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [63:0]   dbg_wdata, dbg_rdata;
    logic          dbg_ack;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata, mem_rdata;

    logic [63:0]   mem [32];
    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [63:0]   pl_data;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_AW(AW), .MAX_CPU_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_misalign(cpu_misalign),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous-read memory with a side preload port owned by the bench.
    always @(posedge clk) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [63:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic cpu_access(input logic we, input logic [63:0] a, input logic [63:0] wd,
                              output logic [63:0] rd, output int mis_cycles, output int cycles);
        bit done = 1'b0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        mis_cycles = 0; cycles = 0; rd = '0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            cycles++;
            if (cpu_misalign) mis_cycles++;
            if (!cpu_stall) begin
                done = 1'b1;
                rd = cpu_rdata;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL cpu_timeout: stall still %b after 20 cycles, required release", cpu_stall);
        end
    endtask

    task automatic dbg_access(input logic we, input logic [AW-1:0] a, input logic [63:0] wd,
                              output logic [63:0] rd, output int cycles);
        bit done = 1'b0;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
        cycles = 0; rd = '0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            cycles++;
            if (dbg_ack) begin
                done = 1'b1;
                rd = dbg_rdata;
            end
        end
        @(posedge clk); #1;
        dbg_req = 1'b0; dbg_we = 1'b0;
        tests_run++;
        if (!done) begin
            tests_failed++;
            $display("FAIL dbg_timeout: no dbg_ack within 20 cycles, required one");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'h13; dbg_req = 1'b1; dbg_we = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if ({cpu_stall, cpu_misalign, dbg_ack, mem_en, mem_we} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_held_outputs: got %b required 00000",
                     {cpu_stall, cpu_misalign, dbg_ack, mem_en, mem_we});
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({cpu_stall, cpu_misalign, dbg_ack, mem_en, mem_we} !== 5'b0 ||
            cpu_rdata !== 64'd0 || dbg_rdata !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_state: ctl=%b cpu_rdata=%h dbg_rdata=%h required all zero",
                     {cpu_stall, cpu_misalign, dbg_ack, mem_en, mem_we}, cpu_rdata, dbg_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_cpu_load();
        preload(5'd2, 64'h1234);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'd16;
        @(negedge clk);
        tests_run++;
        if (cpu_stall !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd2) begin
            tests_failed++;
            $display("FAIL load_issue: stall=%b en=%b we=%b addr=%0d required 1 1 0 2",
                     cpu_stall, mem_en, mem_we, mem_addr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (cpu_stall !== 1'b0 || mem_en !== 1'b0 || cpu_rdata !== 64'h1234) begin
            tests_failed++;
            $display("FAIL load_resp: stall=%b en=%b rdata=%h required 0 0 1234",
                     cpu_stall, mem_en, cpu_rdata);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (cpu_rdata !== 64'h1234 || cpu_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL load_hold: rdata=%h stall=%b required 1234 0", cpu_rdata, cpu_stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_then_dbg();
        logic [63:0] rd;
        int mc, cyc;
        preload(5'd3, 64'd0);
        cpu_access(1'b1, 64'd24, 64'hAB, rd, mc, cyc);
        tests_run++;
        if (cyc != 2 || mc != 0) begin
            tests_failed++;
            $display("FAIL store_cycles: cycles=%0d mis=%0d required 2 0", cyc, mc);
        end
        dbg_access(1'b0, 5'd3, 64'd0, rd, cyc);
        tests_run++;
        if (cyc != 2 || rd !== 64'hAB) begin
            tests_failed++;
            $display("FAIL dbg_read_after_store: cycles=%0d rdata=%h required 2 ab", cyc, rd);
        end
    endtask

    task automatic test_withdraw();
        preload(5'd4, 64'h4444);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd4;
        @(negedge clk);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 64'd8; cpu_wdata = 64'hBAD;
        @(negedge clk);
        tests_run++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== 64'h4444 || cpu_stall !== 1'b1 || mem_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL dbg_resp_with_cpu_wait: ack=%b rdata=%h stall=%b en=%b required 1 4444 1 0",
                     dbg_ack, dbg_rdata, cpu_stall, mem_en);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0; dbg_req = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_en !== 1'b0 || cpu_stall !== 1'b0 || dbg_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL withdraw: en=%b stall=%b ack=%b required 0 0 0", mem_en, cpu_stall, dbg_ack);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        int  g_cyc[$];
        bit  g_dbg[$];
        int  a_cyc[$];
        int  waits;
        bit  exp_dbg;
        preload(5'd5, 64'h55AA);
        preload(5'd9, 64'h9999);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'd40;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_en) begin
                g_cyc.push_back(c);
                g_dbg.push_back(mem_addr == 5'd9);
            end
            if (dbg_ack) a_cyc.push_back(c);
            @(posedge clk); #1;
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        tests_run++;
        if (g_cyc.size() != 10) begin
            tests_failed++;
            $display("FAIL arb_grant_count: got %0d grants required 10", g_cyc.size());
        end
        // Debug is owed the slot once it has watched MAX_CPU_BURST CPU grants go by.
        waits = 0;
        for (int k = 0; k < g_cyc.size() && k < 10; k++) begin
            exp_dbg = (waits == 4);
            waits   = exp_dbg ? 0 : waits + 1;
            tests_run++;
            if (g_dbg[k] !== exp_dbg || g_cyc[k] != 2 * k) begin
                tests_failed++;
                $display("FAIL arb_grant_%0d: dbg=%b at cycle %0d required dbg=%b at cycle %0d",
                         k, g_dbg[k], g_cyc[k], exp_dbg, 2 * k);
            end
        end
        tests_run++;
        if (a_cyc.size() != 2 || (a_cyc.size() == 2 && a_cyc[1] - a_cyc[0] != 10)) begin
            tests_failed++;
            $display("FAIL arb_ack_spacing: %0d acks, spacing %0d required 2 acks spaced 10",
                     a_cyc.size(), (a_cyc.size() == 2) ? a_cyc[1] - a_cyc[0] : -1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misalign();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h13;
        @(negedge clk);
        tests_run++;
        if (cpu_misalign !== 1'b1 || mem_en !== 1'b0 || cpu_stall !== 1'b1) begin
            tests_failed++;
            $display("FAIL misalign_issue: mis=%b en=%b stall=%b required 1 0 1",
                     cpu_misalign, mem_en, cpu_stall);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (cpu_misalign !== 1'b0 || mem_en !== 1'b0 || cpu_stall !== 1'b0 || cpu_rdata !== 64'd0) begin
            tests_failed++;
            $display("FAIL misalign_resp: mis=%b en=%b stall=%b rdata=%h required 0 0 0 0",
                     cpu_misalign, mem_en, cpu_stall, cpu_rdata);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic test_wrap();
        preload(5'd0, 64'hC0FFEE);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 64'h100;
        @(negedge clk);
        tests_run++;
        if (mem_en !== 1'b1 || mem_addr !== 5'd0) begin
            tests_failed++;
            $display("FAIL wrap_addr: en=%b addr=%0d required 1 0", mem_en, mem_addr);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (cpu_rdata !== 64'hC0FFEE) begin
            tests_failed++;
            $display("FAIL wrap_data: rdata=%h required c0ffee", cpu_rdata);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] gm [32];
        logic [63:0] last_cpu, last_dbg, rd, wd, up, a, exp;
        logic [AW-1:0] idx;
        bit   we, mis;
        int   mc, cyc, bad;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        last_cpu = '0; last_dbg = '0;
        for (int i = 0; i < 32; i++) begin
            gm[i] = {$urandom, $urandom};
            preload(AW'(i), gm[i]);
        end
        for (int n = 0; n < 60; n++) begin
            idx = AW'($urandom_range(0, 31));
            we  = $urandom_range(0, 1) == 1;
            wd  = {$urandom, $urandom};
            if ($urandom_range(0, 9) < 7) begin
                up  = {$urandom, $urandom};
                mis = $urandom_range(0, 7) == 0;
                a   = {up[63:8], idx, mis ? 3'($urandom_range(1, 7)) : 3'b000};
                cpu_access(we, a, wd, rd, mc, cyc);
                if (mis) exp = 64'd0;
                else if (we) exp = last_cpu;
                else exp = gm[idx];
                if (mis || !we) last_cpu = exp;
                if (!mis && we) gm[idx] = wd;
                tests_run++;
                if (rd !== exp || cyc != 2 || mc != (mis ? 1 : 0)) begin
                    tests_failed++;
                    $display("FAIL rand_cpu_%0d: we=%b mis=%b rdata=%h cyc=%0d misc=%0d required %h 2 %0d",
                             n, we, mis, rd, cyc, mc, exp, mis ? 1 : 0);
                end
            end else begin
                dbg_access(we, idx, wd, rd, cyc);
                exp = we ? last_dbg : gm[idx];
                last_dbg = exp;
                if (we) gm[idx] = wd;
                tests_run++;
                if (rd !== exp || cyc != 2) begin
                    tests_failed++;
                    $display("FAIL rand_dbg_%0d: we=%b rdata=%h cyc=%0d required %h 2",
                             n, we, rd, cyc, exp);
                end
            end
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== gm[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL rand_mem_image: %0d words differ, required 0", bad);
        end
    endtask

    task automatic test_reset_in_dbg_resp();
        preload(5'd7, 64'd0);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 64'hDEAD;
        @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (dbg_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_drops_ack: ack=%b required 0", dbg_ack);
        end
        @(posedge clk); #1;
        reset = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({cpu_stall, cpu_misalign, dbg_ack, mem_en, mem_we} !== 5'b0 ||
            cpu_rdata !== 64'd0 || dbg_rdata !== 64'd0 || mem[7] !== 64'hDEAD) begin
            tests_failed++;
            $display("FAIL reset_after_dbg: ctl=%b cpu=%h dbg=%h mem7=%h required 00000 0 0 dead",
                     {cpu_stall, cpu_misalign, dbg_ack, mem_en, mem_we}, cpu_rdata, dbg_rdata, mem[7]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        @(posedge clk); #1;
        test_reset();
        test_cpu_load();
        test_store_then_dbg();
        test_withdraw();
        test_arbitration();
        test_misalign();
        test_wrap();
        test_random();
        test_reset_in_dbg_resp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_AW, default 5, meaning doubleword-index width of the data memory (32 entries).
REQ-002 The block SHALL have parameter MAX_CPU_BURST, default 4, meaning consecutive CPU grants allowed while a debug request waits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  MEM-stage access request (ld or sd).
REQ-006 cpu_we  input  1  1 = sd (write), 0 = ld (read).
REQ-007 cpu_addr  input  64  byte address from ALU result.
REQ-008 cpu_wdata  input  64  store data.
REQ-009 cpu_rdata  output  64  load data.
REQ-010 cpu_stall  output  1  freeze pipeline (PC, IF/ID, ID/EX, EX/MEM) this cycle.
REQ-011 cpu_misalign  output  1  one-cycle pulse; cpu_addr[2:0] != 0 on an accepted request.
REQ-012 dbg_req, dbg_we  input  1 each  debug/loader port request and write enable.
REQ-013 dbg_addr  input  MEM_AW  doubleword index; dbg_wdata input 64; dbg_rdata output 64.
REQ-014 dbg_ack  output  1  one-cycle pulse completing a debug access.
REQ-015 mem_en, mem_we  output  1 each  memory strobe and write enable.
REQ-016 mem_addr  output  MEM_AW; mem_wdata output 64; mem_rdata input 64, valid the cycle after mem_en (synchronous read).

Function
REQ-017 FSM states SHALL be IDLE, CPU_RESP, DBG_RESP.
REQ-018 In IDLE, with a request pending, the block SHALL issue exactly one mem_en cycle for the winner and move to CPU_RESP or DBG_RESP.
REQ-019 In CPU_RESP and DBG_RESP the block SHALL drive mem_en=0, latch mem_rdata into cpu_rdata or dbg_rdata, and return to IDLE next cycle.
REQ-020 Each access SHALL take 2 cycles (issue, response); back-to-back grants SHALL therefore be spaced by 2 cycles.
REQ-021 CPU mem_addr SHALL be cpu_addr[MEM_AW+2:3]; upper bits beyond that SHALL be ignored (wrap-around).
REQ-022 cpu_stall SHALL be 1 whenever cpu_req=1 and the state is not CPU_RESP; it SHALL be 0 in CPU_RESP and whenever cpu_req=0.
REQ-023 cpu_rdata SHALL be valid in CPU_RESP and hold its value until the next CPU read response.
REQ-024 Misaligned CPU request: no mem_en; cpu_misalign pulses 1 cycle; FSM goes to CPU_RESP with cpu_rdata=0 so the pipeline advances.
REQ-025 Simultaneous cpu_req and dbg_req in IDLE: CPU SHALL win unless cpu_burst_cnt == MAX_CPU_BURST, in which case debug SHALL win.
REQ-026 cpu_burst_cnt SHALL increment on each CPU grant while dbg_req=1, and clear on a debug grant or when dbg_req=0; it SHALL saturate at MAX_CPU_BURST.
REQ-027 dbg_req SHALL be held by the requester until dbg_ack; dbg_ack SHALL pulse in DBG_RESP with dbg_rdata valid (0 data change for writes).
REQ-028 The memory write SHALL occur at the issue-cycle edge; a write already issued SHALL complete even if reset asserts in the following cycle.
REQ-029 Requests withdrawn before grant SHALL cause no memory access.

Reset
REQ-030 On reset=1 at a rising edge the block SHALL enter IDLE, clear cpu_burst_cnt, cpu_rdata, dbg_rdata to 0, and drive cpu_stall, cpu_misalign, dbg_ack, mem_en, mem_we to 0, regardless of the current state.
REQ-031 A response pending at reset SHALL be dropped (no dbg_ack, no cpu_rdata update).

Verification
REQ-032 Preload mem[2]=0x1234; CPU ld addr 16 -> cycle 1 stall=1, mem_en=1, mem_addr=2; cycle 2 stall=0, cpu_rdata=0x1234.
REQ-033 CPU sd 0xAB to addr 24, then debug read index 3 -> dbg_ack after 2 cycles, dbg_rdata=0xAB.
REQ-034 cpu_req and dbg_req held continuously -> grant order C,C,C,C,D,C,C,C,C,D; dbg_ack every 10 cycles.
REQ-035 CPU ld addr 0x13 -> no mem_en, cpu_misalign=1 one cycle, cpu_rdata=0, stall released next cycle.
REQ-036 Assert reset in DBG_RESP -> next cycle state IDLE, dbg_ack=0, all outputs 0; issued write visible in memory.
REQ-037 cpu_addr 0x100 with MEM_AW=5 -> mem_addr=0 (wrap).
